// File: rtl/mem_access_unit.sv
// MAR/MBR initiator controller for a single-port registered-read memory.
// Accepts one request at a time and returns data or completion.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16384
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READ_WAIT,
    RESP
  } state_t;

  localparam logic [ADDR_WIDTH:0] DepthW =
    (ADDR_WIDTH+1)'(DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mar_q, mar_d;
  logic [DATA_WIDTH-1:0] mbr_q, mbr_d;
  logic                  we_q, we_d;
  logic                  rv_q, rv_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  out_of_range;

  assign req_ready        = (state_q == IDLE) && reset_n;
  assign out_of_range     = {1'b0, req_addr} >= DepthW;
  assign mem_addr         = mar_q;
  assign mem_data_in      = mbr_q;
  assign mem_write_enable = we_q;
  assign resp_valid       = rv_q;
  assign resp_rdata       = rdata_q;
  assign resp_error       = err_q;

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mbr_d   = mbr_q;
    we_d    = we_q;
    rv_d    = rv_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          mar_d = req_addr;
          mbr_d = req_write ? req_wdata : '0;
          if (out_of_range) begin
            state_d = RESP;
            rv_d    = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (req_write) begin
            state_d = WRITE;
            we_d    = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        state_d = RESP;
        we_d    = 1'b0;
        rv_d    = 1'b1;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      READ: begin
        state_d = READ_WAIT;
      end
      READ_WAIT: begin
        // memory output is valid one edge after MAR was presented
        state_d = RESP;
        mbr_d   = mem_data_out;
        rdata_d = mem_data_out;
        rv_d    = 1'b1;
        err_d   = 1'b0;
      end
      RESP: begin
        if (resp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
        rv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mbr_q   <= '0;
      we_q    <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      we_q    <= we_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
